multiplier_scheduler: RTL and testbench
=======================================

# multiplier_scheduler

Sequences M-extension multiply operations onto the single shared `Multiplier_Unit` in the execute stage. Two requesters share it: port 0 is the core pipeline and port 1 is the auxiliary/accelerator issue path. The block arbitrates between them round-robin, drives the multiplier's decode and operand inputs, and tracks `mul_unit_busy` with a watchdog. It returns the captured 32-bit result through a valid/ready response to the requester that was granted.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum cycles in WAIT before an aborted error response; legal range 2..255.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  2  per-port request valid.
- `req_ready`  out  2  per-port request accepted; one-hot or zero.
- `req_funct3_0`, `req_funct3_1`  in  3 each  MUL/MULH/MULHSU/MULHU select.
- `req_accuracy_0`, `req_accuracy_1`  in  8 each  accuracy_level for the approximate multiplier.
- `req_rs1_0`, `req_rs2_0`, `req_rs1_1`, `req_rs2_1`  in  32 each  operands.
- `rsp_valid`  out  2  per-port response valid; at most one bit set.
- `rsp_ready`  in  2  per-port response accept.
- `rsp_data`  out  32  result, shared by both ports.
- `rsp_error`  out  1  high with `rsp_valid` when the watchdog expired.
- `mul_opcode`  out  7  drives Multiplier_Unit `opcode`.
- `mul_funct7`  out  7  drives Multiplier_Unit `funct7`.
- `mul_funct3`  out  3  drives Multiplier_Unit `funct3`.
- `mul_accuracy_level`  out  8  drives Multiplier_Unit `accuracy_level`.
- `mul_rs1`, `mul_rs2`  out  32 each  drive Multiplier_Unit `bus_rs1`/`bus_rs2`.
- `mul_unit_busy`  in  1  from the multiplier.
- `mul_output`  in  32  from the multiplier.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_ready` is asserted to the arbiter winner only; a request is accepted when `req_valid & req_ready`.
  - On accept: latch funct3, accuracy and operands; record the granted port; go to ISSUE.
- Arbitration:
  - If only one port is valid, it wins.
  - If both are valid, the port not granted last time wins.
  - The last-grant pointer updates only on accept.
- ISSUE (exactly 1 cycle):
  - `mul_opcode` = 0110011, `mul_funct7` = 0000001, plus the latched fields.
  - Clear the watchdog; go to WAIT.
- WAIT:
  - The multiplier inputs are held stable.
  - If `mul_unit_busy` = 0: capture `mul_output` into `rsp_data`, set `rsp_error` = 0, go to RESP.
  - Otherwise increment the watchdog. When it reaches TIMEOUT_CYCLES-1 with busy still high, go to RESP with `rsp_data` = 0 and `rsp_error` = 1.
- RESP:
  - `rsp_valid[granted]` is held with `rsp_data`/`rsp_error` stable until `rsp_ready[granted]`; then go to IDLE.
  - `rsp_ready` on the non-granted port is ignored.
- Outside ISSUE and WAIT:
  - `mul_opcode`, `mul_funct7`, `mul_funct3` and `mul_accuracy_level` are driven to 0, so the multiplier sees no M-op.
  - Operand outputs keep their last latched values.
- The result is passed through unmodified (low or high word per funct3). The block performs no sign or width manipulation.

## Timing
- Reset values:
  - State IDLE, last-grant pointer = 1 (port 0 wins first contention).
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_error` = 0.
  - All `mul_*` outputs = 0, watchdog = 0.
- `req_ready` is combinational from state and `req_valid`, and is low outside IDLE.
- Minimum latency: accept in cycle N, ISSUE in N+1, WAIT in N+2 with busy low, `rsp_valid` in N+3.
- Each extra busy cycle adds one cycle of latency.
- Throughput is one op per 4 cycles minimum. There is no overlap: a new request cannot be accepted in the same cycle as the response handshake; acceptance earliest in the following IDLE cycle.
- Busy sampled high in ISSUE is ignored; only WAIT samples busy.
- Reset asserted in any state aborts the operation: no response is issued and all outputs return to reset values on the next edge.
- A `req_valid` drop before acceptance is legal and leaves the pointer unchanged.

## Structure
- Package `mul_sched_pkg` holds:
  - OP_MUL_R = 7'b0110011, FUNCT7_MULDIV = 7'b0000001.
  - funct3 codes MUL=000, MULH=001, MULHSU=010, MULHU=011.
  - The FSM state encoding (2-bit).
- Sub-module `rr_arbiter_2`: 2-input round-robin grant plus last-grant register, updated by an accept strobe.
- The watchdog counter width is $clog2(TIMEOUT_CYCLES).

## Test plan
- Port 0, funct3 = 000, accuracy 0, rs1 = 10, rs2 = 20, busy never high -> `rsp_valid[0]` 3 cycles after accept, `rsp_data` = 200, `rsp_error` = 0.
- Both ports valid in the same cycle after reset (port 0: 3×4, port 1: 5×6) -> port 0 served first (12), then port 1 (30). A repeat of both-valid grants port 1 first.
- Busy held high 5 WAIT cycles, rs1 = 7, rs2 = 9 -> response 5 cycles later than the minimum, data = 63. Multiplier inputs stay stable throughout WAIT.
- Busy stuck high, TIMEOUT_CYCLES = 8 -> `rsp_valid` with `rsp_error` = 1 and data 0 after 8 WAIT cycles; the next request is served normally.
- `rsp_ready` held low for 10 cycles in RESP while port 1 is requesting -> `rsp_valid`/`rsp_data` remain stable and `req_ready` stays 0 until the handshake.
- Reset asserted during WAIT -> no `rsp_valid` is ever raised for that op, and all outputs are zero the next cycle.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared constants, FSM encoding and helpers for the multiplier scheduler.
package mul_sched_pkg;

  localparam logic [6:0] OP_MUL_R      = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } sched_state_t;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter; the last-grant pointer moves only on accept.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic       accept,
  output logic [1:0] grant
);

  // last_grant = 1 means port 1 won the previous accepted request
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/multiplier_scheduler.sv
// Shares one Multiplier_Unit between the core pipeline (port 0) and the
// auxiliary issue path (port 1), with a busy watchdog on each operation.
//
// state    | meaning
// ST_IDLE  | waiting for a request; req_ready follows the arbiter grant
// ST_ISSUE | M-op decode presented to the multiplier for one cycle
// ST_WAIT  | waiting for mul_unit_busy to drop, watchdog running
// ST_RESP  | rsp_valid held on the granted port until its rsp_ready
module multiplier_scheduler
  import mul_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [2:0]  req_funct3_0,
  input  logic [2:0]  req_funct3_1,
  input  logic [7:0]  req_accuracy_0,
  input  logic [7:0]  req_accuracy_1,
  input  logic [31:0] req_rs1_0,
  input  logic [31:0] req_rs2_0,
  input  logic [31:0] req_rs1_1,
  input  logic [31:0] req_rs2_1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic [6:0]  mul_opcode,
  output logic [6:0]  mul_funct7,
  output logic [2:0]  mul_funct3,
  output logic [7:0]  mul_accuracy_level,
  output logic [31:0] mul_rs1,
  output logic [31:0] mul_rs2,
  input  logic        mul_unit_busy,
  input  logic [31:0] mul_output
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  sched_state_t    state;
  logic [1:0]      grant;
  logic            accept;
  logic            sel_port;
  logic            granted;
  logic [WD_W-1:0] watchdog;

  logic [2:0]  sel_funct3;
  logic [7:0]  sel_accuracy;
  logic [31:0] sel_rs1;
  logic [31:0] sel_rs2;

  rr_arbiter_2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .accept    (accept),
    .grant     (grant)
  );

  assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign sel_port  = grant[1];

  assign sel_funct3   = sel_port ? req_funct3_1   : req_funct3_0;
  assign sel_accuracy = sel_port ? req_accuracy_1 : req_accuracy_0;
  assign sel_rs1      = sel_port ? req_rs1_1      : req_rs1_0;
  assign sel_rs2      = sel_port ? req_rs2_1      : req_rs2_0;

  // mul_funct3/mul_accuracy_level double as the operation latches; the
  // operand registers are left alone after the op so the multiplier inputs
  // do not toggle while idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= ST_IDLE;
      granted            <= 1'b0;
      watchdog           <= '0;
      rsp_valid          <= 2'b00;
      rsp_data           <= '0;
      rsp_error          <= 1'b0;
      mul_opcode         <= '0;
      mul_funct7         <= '0;
      mul_funct3         <= '0;
      mul_accuracy_level <= '0;
      mul_rs1            <= '0;
      mul_rs2            <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            granted            <= sel_port;
            mul_opcode         <= OP_MUL_R;
            mul_funct7         <= FUNCT7_MULDIV;
            mul_funct3         <= sel_funct3;
            mul_accuracy_level <= sel_accuracy;
            mul_rs1            <= sel_rs1;
            mul_rs2            <= sel_rs2;
            state              <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          watchdog <= '0;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (!mul_unit_busy || (watchdog == WD_LAST)) begin
            rsp_data           <= mul_unit_busy ? 32'h0 : mul_output;
            rsp_error          <= mul_unit_busy;
            rsp_valid          <= port_onehot(granted);
            mul_opcode         <= '0;
            mul_funct7         <= '0;
            mul_funct3         <= '0;
            mul_accuracy_level <= '0;
            state              <= ST_RESP;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end

        ST_RESP: begin
          if (rsp_ready[granted]) begin
            rsp_valid <= 2'b00;
            rsp_error <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_scheduler.sv
// Directed bench for multiplier_scheduler; the bench also plays the multiplier.
module tb_multiplier_scheduler;
  import mul_sched_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req_funct3_0, req_funct3_1;
  logic [7:0]  req_accuracy_0, req_accuracy_1;
  logic [31:0] req_rs1_0, req_rs2_0, req_rs1_1, req_rs2_1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic [6:0]  mul_opcode, mul_funct7;
  logic [2:0]  mul_funct3;
  logic [7:0]  mul_accuracy_level;
  logic [31:0] mul_rs1, mul_rs2;
  logic        mul_unit_busy;
  logic [31:0] mul_output;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int          port;
    logic [2:0]  f3;
    logic [7:0]  acc;
    logic [31:0] a;
    logic [31:0] b;
    int          busy_n;
    int          hold_n;
    bit          other;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  multiplier_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_funct3_0       (req_funct3_0),
    .req_funct3_1       (req_funct3_1),
    .req_accuracy_0     (req_accuracy_0),
    .req_accuracy_1     (req_accuracy_1),
    .req_rs1_0          (req_rs1_0),
    .req_rs2_0          (req_rs2_0),
    .req_rs1_1          (req_rs1_1),
    .req_rs2_1          (req_rs2_1),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_data           (rsp_data),
    .rsp_error          (rsp_error),
    .mul_opcode         (mul_opcode),
    .mul_funct7         (mul_funct7),
    .mul_funct3         (mul_funct3),
    .mul_accuracy_level (mul_accuracy_level),
    .mul_rs1            (mul_rs1),
    .mul_rs2            (mul_rs2),
    .mul_unit_busy      (mul_unit_busy),
    .mul_output         (mul_output)
  );

  // Multiplier stand-in: only answers a properly decoded M-op
  logic [63:0] ea, eb, prod;
  always_comb begin
    ea   = {{32{mul_rs1[31] & ((mul_funct3 == F3_MULH) | (mul_funct3 == F3_MULHSU))}}, mul_rs1};
    eb   = {{32{mul_rs2[31] & (mul_funct3 == F3_MULH)}}, mul_rs2};
    prod = ea * eb;
    if (mul_opcode == OP_MUL_R && mul_funct7 == FUNCT7_MULDIV)
      mul_output = (mul_funct3 == F3_MUL) ? prod[31:0] : prod[63:32];
    else
      mul_output = 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    if (v.port == 0) begin
      req_funct3_0 = v.f3; req_accuracy_0 = v.acc; req_rs1_0 = v.a; req_rs2_0 = v.b;
    end else begin
      req_funct3_1 = v.f3; req_accuracy_1 = v.acc; req_rs1_1 = v.a; req_rs2_1 = v.b;
    end
    req_valid[v.port] = 1'b1;
  endtask

  // Called just after a rising edge with the request already driven.
  task automatic serve(input string tag, input vec_t v);
    logic [1:0] oh;
    int lat;
    int k;
    oh = (v.port == 1) ? 2'b10 : 2'b01;
    #1;
    chk({tag, ":grant"}, 64'(req_ready), 64'(oh));
    @(posedge clk); #1;
    req_valid[v.port] = 1'b0;
    if (v.other) req_valid[1 - v.port] = 1'b1;
    mul_unit_busy = 1'b1;
    chk({tag, ":issue_ctl"}, {mul_opcode, mul_funct7, mul_funct3, mul_accuracy_level},
        {OP_MUL_R, FUNCT7_MULDIV, v.f3, v.acc});
    chk({tag, ":issue_ops"}, {mul_rs1, mul_rs2}, {v.a, v.b});
    chk({tag, ":issue_ready"}, 64'(req_ready), 64'(0));
    lat = 1;
    k   = 0;
    @(posedge clk); #1; lat++;
    while (rsp_valid == 2'b00 && lat < 40) begin
      mul_unit_busy = (k < v.busy_n);
      k++;
      chk({tag, ":wait_ops"}, {mul_rs1, mul_rs2}, {v.a, v.b});
      chk({tag, ":wait_ctl"}, {mul_opcode, mul_funct7, mul_funct3, mul_accuracy_level},
          {OP_MUL_R, FUNCT7_MULDIV, v.f3, v.acc});
      chk({tag, ":wait_ready"}, 64'(req_ready), 64'(0));
      @(posedge clk); #1; lat++;
    end
    mul_unit_busy = 1'b0;
    chk({tag, ":latency"}, 64'(lat), v.exp_err ? 64'(TO + 2) : 64'(3 + v.busy_n));
    chk({tag, ":rsp_valid"}, 64'(rsp_valid), 64'(oh));
    chk({tag, ":rsp_data"}, 64'(rsp_data), 64'(v.exp_data));
    chk({tag, ":rsp_error"}, 64'(rsp_error), 64'(v.exp_err));
    chk({tag, ":resp_ctl"}, {mul_opcode, mul_funct7, mul_funct3, mul_accuracy_level}, 64'(0));
    for (int i = 0; i < v.hold_n; i++) begin
      rsp_ready = ~oh;
      @(posedge clk); #1;
      chk({tag, ":hold_rsp"}, {rsp_valid, rsp_error, rsp_data}, {oh, v.exp_err, v.exp_data});
      chk({tag, ":hold_ready"}, 64'(req_ready), 64'(0));
    end
    rsp_ready = oh;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    chk({tag, ":done"}, 64'(rsp_valid), 64'(0));
    if (v.other) req_valid = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t c0, c1;
    logic [1:0] seen;

    vecs[0] = '{0, F3_MUL,    8'h00, 32'd10,       32'd20,       0,  0,  1'b0, 32'd200,      1'b0};
    vecs[1] = '{1, F3_MULHU,  8'h55, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,  0,  1'b0, 32'hFFFFFFFE, 1'b0};
    vecs[2] = '{0, F3_MULH,   8'h80, 32'h80000000, 32'h80000000, 2,  0,  1'b0, 32'h40000000, 1'b0};
    vecs[3] = '{1, F3_MULHSU, 8'h03, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,  0,  1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[4] = '{0, F3_MUL,    8'h0F, 32'd7,        32'd9,        5,  0,  1'b0, 32'd63,       1'b0};
    vecs[5] = '{1, F3_MUL,    8'h00, 32'd123,      32'd456,      20, 0,  1'b0, 32'd0,        1'b1};
    vecs[6] = '{0, F3_MUL,    8'h00, 32'd3,        32'd5,        0,  0,  1'b0, 32'd15,       1'b0};
    vecs[7] = '{0, F3_MUL,    8'h01, 32'd100,      32'd100,      0,  10, 1'b1, 32'd10000,    1'b0};

    reset = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00; mul_unit_busy = 1'b0;
    req_funct3_0 = '0; req_funct3_1 = '0; req_accuracy_0 = '0; req_accuracy_1 = '0;
    req_rs1_0 = '0; req_rs2_0 = '0; req_rs1_1 = '0; req_rs2_1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp", {rsp_valid, rsp_error, rsp_data}, 64'(0));
    chk("reset_ctl", {mul_opcode, mul_funct7, mul_funct3, mul_accuracy_level}, 64'(0));
    chk("reset_ops", {mul_rs1, mul_rs2}, 64'(0));
    chk("reset_ready", 64'(req_ready), 64'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    // Contention rounds: port 0 first after reset, then alternate
    c0 = '{0, F3_MUL, 8'h00, 32'd3, 32'd4, 0, 0, 1'b0, 32'd12, 1'b0};
    c1 = '{1, F3_MUL, 8'h00, 32'd5, 32'd6, 0, 0, 1'b0, 32'd30, 1'b0};
    drive(c0); drive(c1);
    serve("rr1", c0);
    drive(c0);
    serve("rr2", c1);
    drive(c1);
    serve("rr3", c0);
    req_valid = 2'b00;

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      serve($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset in the middle of WAIT drops the operation
    c1 = '{1, F3_MUL, 8'h22, 32'd11, 32'd13, 0, 0, 1'b0, 32'd143, 1'b0};
    drive(c1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    mul_unit_busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_rsp", {rsp_valid, rsp_error, rsp_data}, 64'(0));
    chk("rst_ctl", {mul_opcode, mul_funct7, mul_funct3, mul_accuracy_level}, 64'(0));
    chk("rst_ops", {mul_rs1, mul_rs2}, 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    reset = 1'b1;
    mul_unit_busy = 1'b0;
    seen = 2'b00;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid;
    end
    chk("rst_no_rsp", 64'(seen), 64'(0));

    // Pointer is back at its reset value: port 0 wins contention again
    c0 = '{0, F3_MUL, 8'h00, 32'd2, 32'd3, 0, 0, 1'b0, 32'd6,  1'b0};
    c1 = '{1, F3_MUL, 8'h00, 32'd4, 32'd5, 0, 0, 1'b0, 32'd20, 1'b0};
    drive(c0); drive(c1);
    serve("post_rst0", c0);
    serve("post_rst1", c1);
    req_valid = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
